// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset/lock sequencer.
// State encodings and counter sizing helper.
package pll_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_RESET_PLL = 3'd0;
    localparam state_t S_WAIT_LOCK = 3'd1;
    localparam state_t S_STABLE    = 3'd2;
    localparam state_t S_RUN       = 3'd3;
    localparam state_t S_FAILED    = 3'd4;

    // Width able to hold (largest terminal count - 1); never narrower than 1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, async reset to 0.
// Shared by CDC points across the core.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset pulse, debounced lock wait and downstream reset release,
// with lock supervision, timeout retries and software re-sequencing.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_count
);

    localparam int CW = cnt_width(RST_HOLD_CYCLES,
                                  LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

    logic          lock_s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    retry_nxt;
    logic          cnt_run;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        case (state)
            S_RESET_PLL: begin
                if (cnt == HOLD_LAST)
                    state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock has priority over a coincident timeout.
                if (lock_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_count < RETRY_MAX) begin
                        state_nxt = S_RESET_PLL;
                        retry_nxt = retry_count + 2'd1;
                    end else begin
                        state_nxt = S_FAILED;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_RUN;
                    retry_nxt = 2'd0;
                end
            end
            S_RUN: begin
                if (!lock_s || relock_req)
                    state_nxt = S_RESET_PLL;
            end
            S_FAILED: begin
                if (relock_req) begin
                    state_nxt = S_RESET_PLL;
                    retry_nxt = 2'd0;
                end
            end
            default: begin
                state_nxt = S_RESET_PLL;
            end
        endcase
    end

    // RUN and FAILED have no terminal count, so the counter parks there.
    assign cnt_run = (state == S_RESET_PLL) ||
                     (state == S_WAIT_LOCK) ||
                     (state == S_STABLE);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= S_RESET_PLL;
            cnt         <= '0;
            retry_count <= 2'd0;
        end else begin
            state       <= state_nxt;
            retry_count <= retry_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt_run)
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        pll_rst = 1'b0;
        sys_rst = 1'b1;
        ready   = 1'b0;
        fail    = 1'b0;
        case (state)
            S_RESET_PLL: pll_rst = 1'b1;
            S_WAIT_LOCK: ;
            S_STABLE:    ;
            S_RUN: begin
                sys_rst = 1'b0;
                ready   = 1'b1;
            end
            S_FAILED:    fail = 1'b1;
            default:     pll_rst = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small cycle parameters.
// Expected edge counts are hand-derived from the sequencing rules.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;

    int tests_run = 0;
    int tests_failed = 0;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick();
        tick();
        @(negedge refclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({pll_rst, sys_rst, ready, fail} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_outputs got %b want 1100",
                     {pll_rst, sys_rst, ready, fail});
        end
        tests_run++;
        if (retry_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_retry got %0d want 0", retry_count);
        end
    endtask

    task automatic test_clean_lock();
        int n;
        do_reset();
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 100);
        tests_run++;
        if (n != 4) begin
            tests_failed++;
            $display("FAIL clean_rst_pulse got %0d edges want 4", n);
        end
        repeat (10) tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ready !== 1'b1 && n < 100);
        tests_run++;
        if (n != 11) begin
            tests_failed++;
            $display("FAIL clean_ready_delay got %0d edges want 11", n);
        end
        tests_run++;
        if (sys_rst !== 1'b0 || retry_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL clean_run_state got sys_rst=%b retry=%0d want 0/0",
                     sys_rst, retry_count);
        end
    endtask

    task automatic test_loss_and_relock();
        int n;
        int extra;
        pll_locked = 1'b0;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        tests_run++;
        if (ready !== 1'b0 || pll_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL both_entry got ready=%b pll_rst=%b want 0/1",
                     ready, pll_rst);
        end
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 100);
        tests_run++;
        if (n != 4) begin
            tests_failed++;
            $display("FAIL both_rst_pulse got %0d edges want 4", n);
        end
        extra = 0;
        repeat (20) begin
            tick();
            if (pll_rst !== 1'b0) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("FAIL both_single_pulse got %0d extra want 0", extra);
        end
    endtask

    task automatic test_glitchy_lock();
        int n;
        do_reset();
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 100);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ready !== 1'b1 && n < 100);
        tests_run++;
        if (n != 11) begin
            tests_failed++;
            $display("FAIL glitch_ready_delay got %0d edges want 11", n);
        end
        tests_run++;
        if (retry_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL glitch_retry got %0d want 0", retry_count);
        end
    endtask

    task automatic test_timeouts();
        int n;
        int bad;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            n = 0;
            do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 100);
            tests_run++;
            if (n != 4) begin
                tests_failed++;
                $display("FAIL to_rst_pulse%0d got %0d edges want 4", p, n);
            end
            tests_run++;
            if (retry_count !== 2'(p)) begin
                tests_failed++;
                $display("FAIL to_retry%0d got %0d want %0d", p, retry_count, p);
            end
            n = 0;
            do begin
                tick();
                n++;
            end while (pll_rst !== 1'b1 && fail !== 1'b1 && n < 100);
            tests_run++;
            if (n != 32) begin
                tests_failed++;
                $display("FAIL to_wait%0d got %0d edges want 32", p, n);
            end
        end
        tests_run++;
        if ({pll_rst, sys_rst, ready, fail} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL to_failed_outputs got %b want 0101",
                     {pll_rst, sys_rst, ready, fail});
        end
        tests_run++;
        if (retry_count !== 2'd2) begin
            tests_failed++;
            $display("FAIL to_failed_retry got %0d want 2", retry_count);
        end
        bad = 0;
        repeat (200) begin
            tick();
            if (fail !== 1'b1 || pll_rst !== 1'b0 || sys_rst !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL to_failed_hold got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_recovery();
        int n;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        tests_run++;
        if (fail !== 1'b0 || retry_count !== 2'd0 || pll_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL rec_entry got fail=%b retry=%0d pll_rst=%b want 0/0/1",
                     fail, retry_count, pll_rst);
        end
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 100);
        tests_run++;
        if (n != 4) begin
            tests_failed++;
            $display("FAIL rec_rst_pulse got %0d edges want 4", n);
        end
        pll_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ready !== 1'b1 && n < 100);
        tests_run++;
        if (n != 11 || sys_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL rec_ready got %0d edges sys_rst=%b want 11/0",
                     n, sys_rst);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 100);
        pll_locked = 1'b1;
        repeat (5) tick();
        tests_run++;
        if (ready !== 1'b0 || sys_rst !== 1'b1 || pll_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL ar_in_stable got ready=%b sys_rst=%b pll_rst=%b want 0/1/0",
                     ready, sys_rst, pll_rst);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({pll_rst, sys_rst, ready, fail, retry_count} !== 6'b110000) begin
            tests_failed++;
            $display("FAIL ar_immediate got %b want 110000",
                     {pll_rst, sys_rst, ready, fail, retry_count});
        end
        #4 rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 100);
        tests_run++;
        if (n != 4) begin
            tests_failed++;
            $display("FAIL ar_rst_pulse got %0d edges want 4", n);
        end
        n = 0;
        do begin tick(); n++; end while (ready !== 1'b1 && n < 100);
        tests_run++;
        if (n != 9) begin
            tests_failed++;
            $display("FAIL ar_ready_delay got %0d edges want 9", n);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_loss_and_relock();
        test_glitchy_lock();
        test_timeouts();
        test_recovery();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
